// File: rtl/ssd_scan_controller.sv
// Scan controller for a 4-digit common-anode seven-segment display:
// digit registers, slot sequencing with dead-time blanking and anode PWM.
module ssd_scan_controller #(
  parameter int unsigned CLK_DIV      = 100_000,
  parameter int unsigned BLANK_CYCLES = 1_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic [3:0] dp_mask,
  input  logic [3:0] brightness,
  output logic [6:0] ssdCathode,
  output logic       ssdDp,
  output logic [3:0] ssdAnode,
  output logic       scan_tick
);

  localparam int unsigned SHOW_LEN = CLK_DIV - BLANK_CYCLES;
  localparam int unsigned SUB      = SHOW_LEN / 16;
  localparam int unsigned CW       = $clog2(CLK_DIV);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_SHOW  = 2'd2;

  if (BLANK_CYCLES < 1 || CLK_DIV < BLANK_CYCLES + 16) begin : g_illegal
    $error("ssd_scan_controller: need BLANK_CYCLES>=1 and CLK_DIV-BLANK_CYCLES>=16");
  end

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    code_q, code_d;
  logic [3:0]    bri_q, bri_d;
  logic [3:0]    digit_q [4];

  logic [6:0]    cath_q, cath_d;
  logic          dp_q, dp_d;
  logic [3:0]    anode_q, anode_d;
  logic          tick_q, tick_d;
  logic          lit_d;

  // Active-low {a,b,c,d,e,f,g}; 10 is a dash, 11-15 blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    case (code)
      4'd0:    seg_decode = 7'b0000001;
      4'd1:    seg_decode = 7'b1001111;
      4'd2:    seg_decode = 7'b0010010;
      4'd3:    seg_decode = 7'b0000110;
      4'd4:    seg_decode = 7'b1001100;
      4'd5:    seg_decode = 7'b0100100;
      4'd6:    seg_decode = 7'b0100000;
      4'd7:    seg_decode = 7'b0001111;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0000100;
      4'd10:   seg_decode = 7'b1111110;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  // Slot sequencing; digit code and brightness are frozen on entry to SHOW.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    code_d  = code_q;
    bri_d   = bri_q;
    if (!enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_BLANK;
          cnt_d   = '0;
          idx_d   = '0;
        end
        S_BLANK: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
            state_d = S_SHOW;
            code_d  = digit_q[idx_q];
            bri_d   = brightness;
          end
        end
        S_SHOW: begin
          if (cnt_q == CW'(CLK_DIV - 1)) begin
            state_d = S_BLANK;
            cnt_d   = '0;
            idx_d   = idx_q + 2'd1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Outputs are derived from next-state values so they register alongside the state.
  always_comb begin
    lit_d   = (state_d == S_SHOW) &&
              ((32'(cnt_d) - BLANK_CYCLES) < ((32'(bri_d) + 32'd1) * SUB));
    anode_d = lit_d ? ~(4'b0001 << idx_d) : 4'hF;
    cath_d  = lit_d ? seg_decode(code_d) : 7'h7F;
    dp_d    = lit_d ? ~dp_mask[idx_d] : 1'b1;
    tick_d  = (state_d == S_BLANK) && (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      code_q  <= 4'hF;
      bri_q   <= '0;
      anode_q <= 4'hF;
      cath_q  <= 7'h7F;
      dp_q    <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      bri_q   <= bri_d;
      anode_q <= anode_d;
      cath_q  <= cath_d;
      dp_q    <= dp_d;
      tick_q  <= tick_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) digit_q[i] <= 4'hF;
    end else if (wr_en) begin
      digit_q[wr_addr] <= wr_data;
    end
  end

  assign ssdAnode   = anode_q;
  assign ssdCathode = cath_q;
  assign ssdDp      = dp_q;
  assign scan_tick  = tick_q;

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Directed bench for ssd_scan_controller with a short 40-cycle slot (8 blank + 32 show).
module tb_ssd_scan_controller;

  localparam int unsigned CLK_DIV = 40;
  localparam int unsigned BLANK   = 8;

  localparam logic [6:0]  C0    = 7'b0000001;
  localparam logic [6:0]  C1    = 7'b1001111;
  localparam logic [6:0]  C2    = 7'b0010010;
  localparam logic [6:0]  CDASH = 7'b1111110;
  localparam logic [6:0]  COFF  = 7'h7F;
  localparam logic [12:0] DARK  = {1'b0, 4'hF, 1'b1, 7'h7F};

  logic       clk;
  logic       reset;
  logic       enable;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic [3:0] dp_mask;
  logic [3:0] brightness;
  logic [6:0] ssdCathode;
  logic       ssdDp;
  logic [3:0] ssdAnode;
  logic       scan_tick;
  logic [12:0] obs;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  ssd_scan_controller #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .dp_mask    (dp_mask),
    .brightness (brightness),
    .ssdCathode (ssdCathode),
    .ssdDp      (ssdDp),
    .ssdAnode   (ssdAnode),
    .scan_tick  (scan_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {scan_tick, ssdAnode, ssdDp, ssdCathode};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got {tick,anode,dp,cath}=%h expected %h", tag, got, exp);
    end
  endtask

  task automatic dark_cycles(input string tag, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      chk($sformatf("%s c%0d", tag, c), 32'(obs), 32'(DARK));
    end
  endtask

  // Check slot cycles c_from..c_to; cycle 0 is the scan_tick cycle.
  task automatic run_slot(input string tag, input int idx, input logic [6:0] cath,
                          input int on_n, input logic dp_lit, input int c_from, input int c_to);
    for (int c = c_from; c <= c_to; c++) begin
      logic       on;
      logic [3:0] an;
      logic [12:0] e;
      @(negedge clk);
      on = (c >= int'(BLANK)) && (c < int'(BLANK) + on_n);
      an = 4'hF;
      if (on) an[idx] = 1'b0;
      e = {(c == 0), an, (on ? ~dp_lit : 1'b1), (on ? cath : COFF)};
      chk($sformatf("%s c%0d", tag, c), 32'(obs), 32'(e));
    end
  endtask

  initial begin
    logic [3:0] vals [4];
    vals[0] = 4'd0; vals[1] = 4'd2; vals[2] = 4'd0; vals[3] = 4'd1;

    reset = 1'b1; enable = 1'b0; wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'd5;
    dp_mask = 4'b0000; brightness = 4'd15;
    dark_cycles("reset", 5);

    // Digit 0 must still be blank: reset beat the concurrent write.
    reset = 1'b0; wr_en = 1'b0; enable = 1'b1;
    run_slot("blank0", 0, COFF, 32, 1'b0, 0, 39);
    enable = 1'b0;
    dark_cycles("idle", 1);
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 2'(i); wr_data = vals[i];
      dark_cycles("wr", 1);
    end
    wr_en = 1'b0; enable = 1'b1;

    run_slot("full0", 0, C0, 32, 1'b0, 0, 39);
    run_slot("full1", 1, C2, 32, 1'b0, 0, 39);
    run_slot("full2", 2, C0, 32, 1'b0, 0, 39);
    run_slot("full3", 3, C1, 32, 1'b0, 0, 39);

    brightness = 4'd0;
    run_slot("bri0", 0, C0, 2, 1'b0, 0, 39);
    brightness = 4'd7;
    run_slot("bri7", 1, C2, 16, 1'b0, 0, 39);
    run_slot("brimid_a", 2, C0, 16, 1'b0, 0, 19);
    brightness = 4'd15;
    run_slot("brimid_b", 2, C0, 16, 1'b0, 20, 39);
    run_slot("bri15", 3, C1, 32, 1'b0, 0, 39);

    run_slot("wr_pre0", 0, C0, 32, 1'b0, 0, 39);
    run_slot("wrshow_a", 1, C2, 32, 1'b0, 0, 19);
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 4'd10;
    run_slot("wrshow_b", 1, C2, 32, 1'b0, 20, 20);
    wr_en = 1'b0;
    run_slot("wrshow_c", 1, C2, 32, 1'b0, 21, 39);
    dp_mask = 4'b0100;
    run_slot("dp2", 2, C0, 32, 1'b1, 0, 39);
    run_slot("dp3", 3, C1, 32, 1'b0, 0, 39);
    run_slot("dp0", 0, C0, 32, 1'b0, 0, 39);
    run_slot("dash1", 1, CDASH, 32, 1'b0, 0, 39);

    run_slot("dis_a", 2, C0, 32, 1'b1, 0, 15);
    enable = 1'b0;
    dark_cycles("dis", 3);
    enable = 1'b1;
    run_slot("reen0", 0, C0, 32, 1'b0, 0, 39);

    run_slot("rst_a", 1, CDASH, 32, 1'b0, 0, 12);
    reset = 1'b1;
    dark_cycles("rstmid", 1);
    reset = 1'b0;
    run_slot("post0", 0, COFF, 32, 1'b0, 0, 39);
    run_slot("post1", 1, COFF, 32, 1'b0, 0, 39);
    run_slot("post2", 2, COFF, 32, 1'b1, 0, 39);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
